// File: rtl/dff_monitor.sv
// dff_monitor: reader/checker for a registered single-bit path whose DUT has an
// active-low reset. Every Q value coming back from the DUT is compared against
// the D value driven LAT cycles earlier; pass and fail checks are counted.
//
// Parameters
//   LAT       DUT clock-to-Q latency in CLK cycles (1..4)
//   CNT_W     width of the pass / fail counters
// Ports
//   CLK        sole clock, rising edge
//   res        asynchronous active-high reset
//   en         monitor enable; 0 returns to IDLE and stops checking
//   d_obs      D value driven into the DUT
//   q_obs      Q value returned by the DUT
//   dut_n_res  DUT active-low reset as observed
//   pass_cnt   saturating count of passing checks
//   fail_cnt   saturating count of failing checks
//   err        sticky failure flag
//   first_fail check index of the first failure
//   state      current FSM state (0 IDLE, 1 FILL, 2 CHECK)
module dff_monitor #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             res,
  input  logic             en,
  input  logic             d_obs,
  input  logic             q_obs,
  input  logic             dut_n_res,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [7:0]       first_fail,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StCheck = 2'd2,
    StBad   = 2'd3
  } state_e;

  // FILL ends on the edge where the fill counter reaches this value.
  localparam logic [1:0] FillLast = 2'(LAT - 1);

  state_e             r_state;
  logic   [1:0]       r_fcnt;
  logic   [LAT-1:0]   r_vld;
  logic   [LAT-1:0]   r_dat;
  logic   [CNT_W-1:0] r_pass;
  logic   [CNT_W-1:0] r_fail;
  logic               r_err;
  logic   [7:0]       r_first;
  logic   [7:0]       r_idx;

  state_e             w_state_d;
  logic   [1:0]       w_fcnt_d;
  logic   [LAT-1:0]   w_vld_d;
  logic   [LAT-1:0]   w_dat_d;
  logic               w_chk;
  logic               w_exp;
  logic               w_pass;
  logic               w_fail;

  // Next-state, pipeline shift and check selection.
  always_comb begin
    w_state_d = r_state;
    w_fcnt_d  = r_fcnt;
    w_vld_d   = r_vld;
    w_dat_d   = r_dat;
    w_chk     = 1'b0;
    w_exp     = 1'b0;
    case (r_state)
      StIdle: begin
        if (en) begin
          w_state_d = StFill;
          w_fcnt_d  = '0;
          w_vld_d   = '0;
          w_dat_d   = '0;
        end
      end
      StFill, StCheck: begin
        if (!en) begin
          // en=0 wins over everything, including a DUT reset at the same edge.
          w_state_d = StIdle;
        end else if (!dut_n_res) begin
          // DUT in reset: Q must read 0, history is meaningless, refill afterwards.
          w_chk     = 1'b1;
          w_exp     = 1'b0;
          w_vld_d   = '0;
          w_dat_d   = '0;
          w_state_d = StFill;
          w_fcnt_d  = '0;
        end else begin
          w_vld_d[0] = 1'b1;
          w_dat_d[0] = d_obs;
          for (int i = 1; i < int'(LAT); i++) begin
            w_vld_d[i] = r_vld[i-1];
            w_dat_d[i] = r_dat[i-1];
          end
          if (r_state == StFill) begin
            if (r_fcnt == FillLast) begin
              w_state_d = StCheck;
            end else begin
              w_fcnt_d = r_fcnt + 2'd1;
            end
          end else begin
            // Compare against the oldest stage as held before this edge's shift.
            w_chk = r_vld[LAT-1];
            w_exp = r_dat[LAT-1];
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // An X/Z on q_obs makes the equality unknown, which falls to the failing branch.
  always_comb begin
    w_pass = 1'b0;
    w_fail = 1'b0;
    if (w_chk) begin
      if (q_obs == w_exp) begin
        w_pass = 1'b1;
      end else begin
        w_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge res) begin
    if (res) begin
      r_state <= StIdle;
      r_fcnt  <= '0;
      r_vld   <= '0;
      r_dat   <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_err   <= 1'b0;
      r_first <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_fcnt  <= w_fcnt_d;
      r_vld   <= w_vld_d;
      r_dat   <= w_dat_d;
      if (w_pass && (r_pass != {CNT_W{1'b1}})) begin
        r_pass <= r_pass + 1'b1;
      end
      if (w_fail) begin
        if (r_fail != {CNT_W{1'b1}}) begin
          r_fail <= r_fail + 1'b1;
        end
        if (!r_err) begin
          r_err   <= 1'b1;
          r_first <= r_idx;
        end
      end
      if (w_chk && (r_idx != 8'hFF)) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign pass_cnt   = r_pass;
  assign fail_cnt   = r_fail;
  assign err        = r_err;
  assign first_fail = r_first;
  assign state      = r_state;

endmodule
